// File: rtl/irq_pkg.sv
// Shared types for the interrupt/exception sequencer: FSM states, cause codes
// and the fixed arbitration order over the pending-bit vector.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_EXC   = 3'd1,
        CAUSE_SYS   = 3'd2,
        CAUSE_PORT0 = 3'd4,
        CAUSE_PORT1 = 3'd5,
        CAUSE_PORT2 = 3'd6,
        CAUSE_PORT3 = 3'd7
    } cause_t;

    // Pending vector layout: [0]=exception, [1]=syscall, [5:2]=port 3..0
    localparam int unsigned PEND_W    = 6;
    localparam int unsigned IDX_EXC   = 0;
    localparam int unsigned IDX_SYS   = 1;
    localparam int unsigned IDX_PORT0 = 2;

    typedef logic [2:0] pidx_t;

    // Highest priority first
    localparam pidx_t PRIO_ORDER [PEND_W] = '{
        3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd2
    };

    function automatic cause_t idx_to_cause(input pidx_t idx);
        case (idx)
            3'd0:    return CAUSE_EXC;
            3'd1:    return CAUSE_SYS;
            3'd2:    return CAUSE_PORT0;
            3'd3:    return CAUSE_PORT1;
            3'd4:    return CAUSE_PORT2;
            3'd5:    return CAUSE_PORT3;
            default: return CAUSE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/irq_if.sv
// Request/handshake bundle between the interrupt sequencer (slave) and the
// processor control unit plus event sources (master).
interface irq_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_except;
    logic [3:0]        i_port;
    logic              i_syscall;
    logic [7:0]        inmediate_for_syscall;
    logic              s_accept;
    logic              s_finished;
    logic              s_interruption;
    logic [ADDR_W-1:0] dir_from_exception;
    logic [2:0]        cause;
    logic              s_overrun;

    modport slave (
        input  i_except, i_port, i_syscall, inmediate_for_syscall,
        input  s_accept, s_finished,
        output s_interruption, dir_from_exception, cause, s_overrun
    );

    modport master (
        output i_except, i_port, i_syscall, inmediate_for_syscall,
        output s_accept, s_finished,
        input  s_interruption, dir_from_exception, cause, s_overrun
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: picks the highest-priority pending source and
// reports it both one-hot (for clearing) and as a cause code.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [PEND_W-1:0] pend,
    output logic [PEND_W-1:0] win,
    output cause_t            cause
);
    logic found;

    always_comb begin
        win   = '0;
        cause = CAUSE_NONE;
        found = 1'b0;
        for (int unsigned i = 0; i < PEND_W; i++) begin
            if (!found && pend[PRIO_ORDER[i]]) begin
                win[PRIO_ORDER[i]] = 1'b1;
                cause              = idx_to_cause(PRIO_ORDER[i]);
                found              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Interrupt/exception sequencer: latches requests, arbitrates by fixed priority,
// presents one vector to the control unit and blocks nesting until return.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 10,
    parameter logic [ADDR_W-1:0] EXC_VEC       = 10'h3F8,
    parameter logic [ADDR_W-1:0] PORT_VEC_BASE = 10'h3E0,
    parameter logic [ADDR_W-1:0] SYS_BASE      = 10'h200
) (
    input  logic  clk,
    input  logic  reset,
    irq_if.slave  bus
);
    state_t            state;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] set_v;
    logic [PEND_W-1:0] clr_v;
    logic [PEND_W-1:0] win;
    logic [PEND_W-1:0] win_q;
    cause_t            win_cause;
    cause_t            cause_q;
    logic [7:0]        sys_num;
    logic [3:0]        port_hist;
    logic [ADDR_W-1:0] vec;
    logic [ADDR_W-1:0] dir_q;
    logic              overrun_q;

    irq_prio_enc u_prio (
        .pend  (pend),
        .win   (win),
        .cause (win_cause)
    );

    always_comb begin
        set_v                  = '0;
        set_v[IDX_EXC]         = bus.i_except;
        set_v[IDX_SYS]         = bus.i_syscall & ~pend[IDX_SYS];
        set_v[IDX_PORT0 +: 4]  = bus.i_port & ~port_hist;
    end

    // win_q remembers which pending bit the current grant must retire
    assign clr_v = (state == ST_REQUEST && bus.s_accept) ? win_q : '0;

    always_comb begin
        vec = '0;
        case (win_cause)
            CAUSE_EXC:   vec = EXC_VEC;
            CAUSE_SYS:   vec = SYS_BASE + ADDR_W'(sys_num);
            CAUSE_PORT0: vec = PORT_VEC_BASE;
            CAUSE_PORT1: vec = PORT_VEC_BASE + ADDR_W'(4);
            CAUSE_PORT2: vec = PORT_VEC_BASE + ADDR_W'(8);
            CAUSE_PORT3: vec = PORT_VEC_BASE + ADDR_W'(12);
            default:     vec = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend      <= '0;
            win_q     <= '0;
            sys_num   <= '0;
            port_hist <= '0;
            dir_q     <= '0;
            cause_q   <= CAUSE_NONE;
            overrun_q <= 1'b0;
        end else begin
            pend      <= (pend & ~clr_v) | set_v;
            port_hist <= bus.i_port;
            if (set_v[IDX_SYS])
                sys_num <= bus.inmediate_for_syscall;
            if (bus.i_syscall && pend[IDX_SYS])
                overrun_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        dir_q   <= vec;
                        cause_q <= win_cause;
                        win_q   <= win;
                        state   <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (bus.s_accept)
                        state <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (bus.s_finished) begin
                        cause_q <= CAUSE_NONE;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_interruption     = (state == ST_REQUEST);
    assign bus.dir_from_exception = dir_q;
    assign bus.cause              = cause_q;
    assign bus.s_overrun          = overrun_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the request/grant rules.
module tb_irq_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    irq_if #(.ADDR_W(10)) bus ();

    irq_controller #(
        .ADDR_W        (10),
        .EXC_VEC       (10'h3F8),
        .PORT_VEC_BASE (10'h3E0),
        .SYS_BASE      (10'h200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pending flags, phase 0=waiting 1=offering 2=in routine
    bit       m_exc, m_sys, m_ovr;
    bit [3:0] m_port, m_prev;
    int       m_num, m_phase, m_dir, m_cause;

    function automatic int pick_cause();
        if (m_exc) return 1;
        if (m_sys) return 2;
        for (int n = 3; n >= 0; n--)
            if (m_port[n]) return 4 + n;
        return 0;
    endfunction

    function automatic int vec_of(input int c);
        if (c == 1) return 'h3F8;
        if (c == 2) return ('h200 + m_num) % 1024;
        return ('h3E0 + 4 * (c - 4)) % 1024;
    endfunction

    task automatic model_reset();
        m_exc = 0; m_sys = 0; m_ovr = 0; m_port = 0; m_prev = 0;
        m_num = 0; m_phase = 0; m_dir = 0; m_cause = 0;
    endtask

    task automatic model_step();
        bit old_sys;
        int c;
        old_sys = m_sys;
        c = pick_cause();
        if (m_phase == 0 && c != 0) begin
            m_dir = vec_of(c); m_cause = c; m_phase = 1;
        end else if (m_phase == 1 && bus.s_accept) begin
            if (m_cause == 1) m_exc = 0;
            else if (m_cause == 2) m_sys = 0;
            else m_port[m_cause - 4] = 0;
            m_phase = 2;
        end else if (m_phase == 2 && bus.s_finished) begin
            m_cause = 0; m_phase = 0;
        end
        if (bus.i_except) m_exc = 1;
        if (bus.i_syscall) begin
            if (!old_sys) begin m_sys = 1; m_num = int'(bus.inmediate_for_syscall); end
            else m_ovr = 1;
        end
        for (int n = 0; n < 4; n++)
            if (bus.i_port[n] && !m_prev[n]) m_port[n] = 1;
        m_prev = bus.i_port;
    endtask

    task automatic compare();
        chk("s_int", 32'(bus.s_interruption), 32'(m_phase == 1));
        chk("dir",   32'(bus.dir_from_exception), 32'(m_dir));
        chk("cause", 32'(bus.cause), 32'(m_cause));
        chk("ovr",   32'(bus.s_overrun), 32'(m_ovr));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    endtask

    task automatic drive_zero();
        bus.i_except = 0; bus.i_port = '0; bus.i_syscall = 0;
        bus.inmediate_for_syscall = '0; bus.s_accept = 0; bus.s_finished = 0;
    endtask

    task automatic serve(output int got);
        int k;
        k = 0;
        while (!bus.s_interruption && k < 20) begin cyc(1); k++; end
        if (k == 20) chk("serve_timeout", 32'(k), 32'd0);
        got = int'(bus.dir_from_exception);
        bus.s_accept = 1;   cyc(1); bus.s_accept = 0;
        bus.s_finished = 1; cyc(1); bus.s_finished = 0;
    endtask

    int g;

    initial begin
        drive_zero();
        reset = 1'b1;
        model_reset();
        #3 compare();
        @(posedge clk); #1;
        compare();
        reset = 1'b0;

        // single port event, accepted in the first offered cycle
        bus.i_port = 4'b0100; bus.s_accept = 1;
        cyc(1); chk("p_pre_int", 32'(bus.s_interruption), 32'd0);
        bus.i_port = 4'b0000;
        cyc(1);
        chk("p_int",   32'(bus.s_interruption), 32'd1);
        chk("p_dir",   32'(bus.dir_from_exception), 32'h3E8);
        chk("p_cause", 32'(bus.cause), 32'd6);
        cyc(1); chk("p_svc_int", 32'(bus.s_interruption), 32'd0);
        bus.s_accept = 0; bus.s_finished = 1; cyc(1); bus.s_finished = 0;
        cyc(2);

        // simultaneous sources are granted in priority order
        bus.i_except = 1; bus.i_syscall = 1; bus.inmediate_for_syscall = 8'h15;
        bus.i_port = 4'b0001;
        cyc(1);
        drive_zero();
        serve(g); chk("sim_1", 32'(g), 32'h3F8);
        serve(g); chk("sim_2", 32'(g), 32'h215);
        serve(g); chk("sim_3", 32'(g), 32'h3E0);
        cyc(2);

        // second syscall while one is pending is dropped and flagged
        bus.i_syscall = 1; bus.inmediate_for_syscall = 8'h21; cyc(1);
        bus.inmediate_for_syscall = 8'h33; cyc(1);
        drive_zero();
        chk("ovr_set", 32'(bus.s_overrun), 32'd1);
        serve(g); chk("ovr_vec", 32'(g), 32'h221);
        cyc(2);

        // a higher-priority arrival does not retarget an offered vector
        bus.i_port = 4'b0010; cyc(1);
        bus.i_port = 4'b0000; cyc(1);
        bus.i_except = 1; cyc(1);
        bus.i_except = 0; cyc(2);
        chk("nrt_int", 32'(bus.s_interruption), 32'd1);
        chk("nrt_dir", 32'(bus.dir_from_exception), 32'h3E4);
        serve(g); chk("nrt_1", 32'(g), 32'h3E4);
        serve(g); chk("nrt_2", 32'(g), 32'h3F8);
        cyc(2);

        // a new rise on the clearing edge keeps the bit pending
        bus.i_port = 4'b0100; cyc(1);
        bus.i_port = 4'b0000; cyc(1);
        bus.i_port = 4'b0100; bus.s_accept = 1; cyc(1);
        bus.i_port = 4'b0000; bus.s_accept = 0;
        bus.s_finished = 1; cyc(1); bus.s_finished = 0;
        chk("sbc_cause0", 32'(bus.cause), 32'd0);
        cyc(1);
        chk("sbc_int", 32'(bus.s_interruption), 32'd1);
        chk("sbc_dir", 32'(bus.dir_from_exception), 32'h3E8);
        serve(g);
        bus.s_finished = 1; cyc(2); bus.s_finished = 0;
        chk("stray_int", 32'(bus.s_interruption), 32'd0);
        chk("stray_cause", 32'(bus.cause), 32'd0);

        // asynchronous reset in the middle of a service routine
        bus.i_port = 4'b1000; cyc(1);
        bus.i_port = 4'b0000; bus.s_accept = 1; cyc(2);
        bus.s_accept = 0;
        chk("ar_cause", 32'(bus.cause), 32'd7);
        chk("ar_ovr_sticky", 32'(bus.s_overrun), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1 compare();
        bus.i_port = 4'b0001;
        @(posedge clk); #1;
        compare();
        reset = 1'b0;
        cyc(1);
        cyc(1);
        chk("ar_req_dir", 32'(bus.dir_from_exception), 32'h3E0);
        serve(g);
        cyc(5);
        chk("ar_once", 32'(bus.s_interruption), 32'd0);
        drive_zero();
        cyc(1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.i_except  = ($urandom_range(15) == 0);
            bus.i_syscall = ($urandom_range(7) == 0);
            bus.inmediate_for_syscall = 8'($urandom);
            if ($urandom_range(3) == 0) bus.i_port = 4'($urandom);
            bus.s_accept   = ($urandom_range(1) == 0);
            bus.s_finished = ($urandom_range(2) == 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt/exception sequencer for the single-cycle 10-bit-PC processor. It latches requests from the synchronous exception line, the four input-port event lines and the syscall instruction. It arbitrates them by fixed priority and presents one vector address plus a request flag to the control unit; the datapath's interrupt-select mux consumes that address when redirecting the PC. It blocks further redirects until the control unit signals completion of the service routine, so routines do not nest.

## Interface
Parameters:
- ADDR_W, 10, width of PC/vector addresses
- EXC_VEC, 10'h3F8, exception vector
- PORT_VEC_BASE, 10'h3E0, vector for port n is PORT_VEC_BASE + 4·n
- SYS_BASE, 10'h200, syscall vector is SYS_BASE + syscall number (zero-extended)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_except  in  1  exception request, sampled each edge
- i_port  in  4  port event lines; a rising level (0→1 between samples) requests
- i_syscall  in  1  syscall request, asserted for the cycle the syscall instruction executes
- inmediate_for_syscall  in  8  syscall number, valid while i_syscall=1
- s_accept  in  1  control unit takes the redirect this cycle
- s_finished  in  1  control unit executed return-from-interrupt
- s_interruption  out  1  redirect requested
- dir_from_exception  out  ADDR_W  vector address
- cause  out  3  0=none, 1=exception, 2=syscall, 4..7=port 0..3
- s_overrun  out  1  sticky: a syscall was dropped

## Operation
- Pending bits: exc_p, sys_p, port_p[3:0]; syscall number register sys_num[7:0].
- Set rules, evaluated every edge in every state:
  - i_except=1 sets exc_p.
  - i_syscall=1 with sys_p=0 sets sys_p and loads sys_num.
  - i_syscall=1 with sys_p=1 is dropped, sys_num is unchanged, and s_overrun is set.
  - i_port[n]=1 with last-sampled i_port[n]=0 sets port_p[n].
- The edge-detect history registers reset to 0, so a line that is already high at reset release requests once.
- Priority: exception > syscall > port 3 > port 2 > port 1 > port 0.
- States:
  - IDLE: on any pending bit, latch the winner's vector into dir_from_exception and its code into cause, then go to REQUEST.
  - REQUEST: s_interruption=1. On s_accept, clear the winner's pending bit and go to SERVICE. The vector is frozen; a higher-priority arrival does not retarget.
  - SERVICE: s_interruption=0. On s_finished, go to IDLE and set cause to 0. dir_from_exception holds its value.
- s_accept outside REQUEST and s_finished outside SERVICE are ignored.
- If a set and a clear hit the same bit on the same edge, the set wins and the bit stays pending.
- Vector arithmetic is modulo 2^ADDR_W with no saturation.

## Timing
- Reset values: state IDLE, every pending bit 0, sys_num 0, port history 0, s_interruption 0, dir_from_exception 0, cause 0, s_overrun 0.
- s_interruption is decoded from state. dir_from_exception and cause are registered.
- Latency: a request sampled at edge k sets pending after k. At edge k+1 the block enters REQUEST, so s_interruption=1 during cycle k+1..k+2. With s_accept in the first REQUEST cycle, SERVICE is reached after edge k+2.
- Minimum IDLE dwell is 1 cycle. The next pending request is granted one edge after the return to IDLE.
- Asserting reset in any state returns the block to reset values immediately, without waiting for clk. Pending requests are lost.

## Structure
- Shared package irq_pkg holds:
  - state encoding IDLE/REQUEST/SERVICE;
  - cause codes CAUSE_NONE=0, CAUSE_EXC=1, CAUSE_SYS=2, CAUSE_PORT0..3=4..7;
  - the priority order.
- One combinational sub-module, irq_prio_enc: pending vector in; winner one-hot and cause code out. Vector computation stays in the top.

## Test plan
- Port event: reset, pulse i_port=4'b0100 for 1 cycle, hold s_accept=1 → s_interruption=1 exactly one cycle, dir_from_exception=10'h3E8, cause=6, then state SERVICE.
- Simultaneous events: on the same edge, i_except=1, i_syscall=1 (num 8'h15) and i_port[0] rises; cycle each ISR with s_accept then s_finished → grants in the order 10'h3F8, 10'h215, 10'h3E0.
- Syscall overrun: a second i_syscall (num 8'h33) arrives while sys_p=1 → s_overrun=1; the served vector stays 10'h200+first num; s_overrun persists until reset.
- No retargeting: hold s_accept=0 in REQUEST for a port-1 request (10'h3E4) and raise i_except → dir stays 10'h3E4; exception is granted after s_finished, at 10'h3F8.
- Set beats clear: i_port[2] rises again on the same edge s_accept clears port_p[2] → port 2 is granted again after s_finished; stray s_finished in IDLE causes no change.
- Async reset: assert reset mid-SERVICE, between clock edges → all outputs are 0 before the next clk edge; a port line held high at release produces one request.
